cog_ctr_cap: RTL and testbench

COG_CTR_CAP -- requirements
Module: cog_ctr_cap

---
 rtl/cog_ctr_cap_if.sv | 28 ++
 rtl/cog_ctr_cap.sv | 112 +++++++++++
 tb/tb_cog_ctr_cap.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cog_ctr_cap_if.sv
// cog_ctr_cap_if: configuration, pin/phase inputs and capture FIFO read port.
// Revision: 1.0
`default_nettype none

interface cog_ctr_cap_if;
    logic        setcap;
    logic [31:0] data;
    logic [31:0] pin_in;
    logic [32:0] phs;
    logic        rd;
    logic        ovf_clr;
    logic        cap_valid;
    logic [32:0] cap_data;
    logic [4:0]  cap_count;
    logic        overflow;

    modport master (
        output setcap, data, pin_in, phs, rd, ovf_clr,
        input  cap_valid, cap_data, cap_count, overflow
    );

    modport slave (
        input  setcap, data, pin_in, phs, rd, ovf_clr,
        output cap_valid, cap_data, cap_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/cog_ctr_cap.sv
// cog_ctr_cap: pin edge detector that captures the phase accumulator into a FIFO.
// Revision: 1.0
`default_nettype none

module cog_ctr_cap #(
    parameter int DEPTH = 4
) (
    input  wire logic      clk_cog,
    input  wire logic      reset,
    cog_ctr_cap_if.slave   bus
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ARM = 2'd1,
        S_RUN = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_hist;
    logic [4:0]        r_cfg_pin;
    logic [1:0]        r_cfg_mode;
    logic [32:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [4:0]        r_count;
    logic              r_ovf;

    logic              w_pin;
    logic [1:0]        w_hist_nxt;
    logic              w_rise;
    logic              w_fall;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_flush;
    logic              w_wr;
    logic              w_drop;

    // Detect on the value being sampled so the phase of the transition cycle is captured.
    assign w_pin      = bus.pin_in[r_cfg_pin];
    assign w_hist_nxt = {r_hist[0], w_pin};
    assign w_rise     = (r_state == S_RUN) && (w_hist_nxt == 2'b01) && r_cfg_mode[0];
    assign w_fall     = (r_state == S_RUN) && (w_hist_nxt == 2'b10) && r_cfg_mode[1];
    assign w_push     = w_rise || w_fall;
    assign w_full     = (r_count == 5'(DEPTH));
    assign w_pop      = bus.rd && (r_count != 5'd0);
    assign w_flush    = bus.setcap && bus.data[7];
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop && !w_flush;

    always_ff @(posedge clk_cog) begin
        if (reset) begin
            r_state    <= S_OFF;
            r_hist     <= 2'b00;
            r_cfg_pin  <= 5'd0;
            r_cfg_mode <= 2'b00;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= 5'd0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (bus.setcap) begin
                r_cfg_pin  <= bus.data[4:0];
                r_cfg_mode <= bus.data[6:5];
                r_state    <= (bus.data[6:5] == 2'b00) ? S_OFF : S_ARM;
            end else if (r_state == S_ARM) begin
                r_state <= S_RUN;
            end

            // Arming preloads both history bits so a stale level never reads as an edge.
            case (r_state)
                S_ARM:   r_hist <= {w_pin, w_pin};
                S_RUN:   r_hist <= w_hist_nxt;
                default: r_hist <= r_hist;
            endcase

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= 5'd0;
            end else begin
                if (w_wr) begin
                    r_mem[r_wptr] <= bus.phs;
                    r_wptr        <= r_wptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_AW'(1);
                end
                r_count <= r_count + 5'(w_wr) - 5'(w_pop);
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.cap_valid = (r_count != 5'd0);
    assign bus.cap_data  = r_mem[r_rptr];
    assign bus.cap_count = r_count;
    assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cog_ctr_cap.sv
// tb_cog_ctr_cap: directed scenario bench for the phase capture FIFO.
// Revision: 1.0
`default_nettype none

module tb_cog_ctr_cap;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cog_ctr_cap_if bus ();

    cog_ctr_cap #(.DEPTH(4)) dut (
        .clk_cog (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_setcap(input logic [31:0] v);
        bus.setcap = 1'b1;
        bus.data   = v;
        tick();
        bus.setcap = 1'b0;
        bus.data   = 32'h0;
    endtask

    task automatic rise_edge(input logic [32:0] v);
        bus.pin_in = 32'h20;
        bus.phs    = v;
        tick();
        bus.pin_in = 32'h0;
        tick();
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.cap_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.cap_valid); end
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.cap_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        n_cmp++; if (bus.cap_data !== 33'h0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.cap_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rise_capture();
        do_setcap(32'h25);
        tick();
        bus.pin_in = 32'h20;
        bus.phs    = 33'h0_0000_1000;
        tick();
        n_cmp++; if (bus.cap_valid !== 1'b1) begin n_err++; $display("FAIL rise_valid got %b want 1", bus.cap_valid); end
        n_cmp++; if (bus.cap_data !== 33'h0_0000_1000) begin n_err++; $display("FAIL rise_data got %h want 000001000", bus.cap_data); end
        n_cmp++; if (bus.cap_count !== 5'd1) begin n_err++; $display("FAIL rise_count got %0d want 1", bus.cap_count); end
        bus.phs = 33'h0_0000_1001;
        tick();
        bus.pin_in = 32'h0;
        tick();
        n_cmp++; if (bus.cap_count !== 5'd1) begin n_err++; $display("FAIL rise_only_count got %0d want 1", bus.cap_count); end
        n_cmp++; if (bus.cap_data !== 33'h0_0000_1000) begin n_err++; $display("FAIL rise_hold_data got %h want 000001000", bus.cap_data); end
        pop();
        n_cmp++; if (bus.cap_valid !== 1'b0) begin n_err++; $display("FAIL pop_valid got %b want 0", bus.cap_valid); end
        pop();
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL empty_rd_count got %0d want 0", bus.cap_count); end
    endtask

    task automatic test_arming();
        bus.pin_in = 32'h8;
        do_setcap(32'h63);
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL arm_setcap_count got %0d want 0", bus.cap_count); end
        tick();
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL arm_arm_count got %0d want 0", bus.cap_count); end
        tick();
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL arm_run1_count got %0d want 0", bus.cap_count); end
        bus.pin_in = 32'h0;
        bus.phs    = 33'h0_0000_2222;
        tick();
        tick();
        n_cmp++; if (bus.cap_count !== 5'd1) begin n_err++; $display("FAIL arm_fall_count got %0d want 1", bus.cap_count); end
        n_cmp++; if (bus.cap_data !== 33'h0_0000_2222) begin n_err++; $display("FAIL arm_fall_data got %h want 000002222", bus.cap_data); end
        pop();
    endtask

    task automatic test_overflow();
        do_setcap(32'h25);
        tick();
        for (int i = 0; i < 5; i++) rise_edge(33'h100 + 33'(i));
        n_cmp++; if (bus.cap_count !== 5'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", bus.cap_count); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
        bus.pin_in  = 32'h20;
        bus.phs     = 33'h1ff;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        bus.pin_in  = 32'h0;
        tick();
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_vs_drop got %b want 1", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.cap_data !== 33'h100 + 33'(i)) begin n_err++; $display("FAIL ovf_order[%0d] got %h want %h", i, bus.cap_data, 33'h100 + 33'(i)); end
            pop();
        end
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL ovf_drain_count got %0d want 0", bus.cap_count); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 4; i++) rise_edge(33'h200 + 33'(i));
        bus.pin_in = 32'h20;
        bus.phs    = 33'h204;
        bus.rd     = 1'b1;
        tick();
        bus.rd     = 1'b0;
        bus.pin_in = 32'h0;
        n_cmp++; if (bus.cap_count !== 5'd4) begin n_err++; $display("FAIL full_count got %0d want 4", bus.cap_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf got %b want 0", bus.overflow); end
        n_cmp++; if (bus.cap_data !== 33'h201) begin n_err++; $display("FAIL full_head got %h want 000000201", bus.cap_data); end
        tick();
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (bus.cap_data !== 33'h200 + 33'(i)) begin n_err++; $display("FAIL full_order[%0d] got %h want %h", i, bus.cap_data, 33'h200 + 33'(i)); end
            pop();
        end
    endtask

    task automatic test_flush_carry();
        bus.pin_in = 32'h20;
        bus.phs    = 33'h1_FFFF_FFFF;
        tick();
        bus.pin_in = 32'h0;
        n_cmp++; if (bus.cap_data[32] !== 1'b1) begin n_err++; $display("FAIL carry_bit got %b want 1", bus.cap_data[32]); end
        n_cmp++; if (bus.cap_data !== 33'h1_FFFF_FFFF) begin n_err++; $display("FAIL carry_data got %h want 1ffffffff", bus.cap_data); end
        tick();
        bus.pin_in = 32'h20;
        bus.phs    = 33'h123;
        do_setcap(32'hA5);
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.cap_count); end
        n_cmp++; if (bus.cap_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.cap_valid); end
        tick();
        bus.pin_in = 32'h0;
        tick();
        bus.pin_in = 32'h20;
        bus.phs    = 33'h55;
        bus.rd     = 1'b1;
        tick();
        bus.rd = 1'b0;
        n_cmp++; if (bus.cap_count !== 5'd1) begin n_err++; $display("FAIL empty_push_rd_count got %0d want 1", bus.cap_count); end
        n_cmp++; if (bus.cap_data !== 33'h55) begin n_err++; $display("FAIL empty_push_rd_data got %h want 000000055", bus.cap_data); end
        bus.pin_in = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 5; i++) rise_edge(33'h300 + 33'(i));
        pop();
        n_cmp++; if (bus.cap_count !== 5'd3) begin n_err++; $display("FAIL mid_pre_count got %0d want 3", bus.cap_count); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre_ovf got %b want 1", bus.overflow); end
        reset      = 1'b1;
        bus.pin_in = 32'h20;
        bus.phs    = 33'h999;
        tick();
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", bus.cap_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b want 0", bus.overflow); end
        n_cmp++; if (bus.cap_data !== 33'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", bus.cap_data); end
        reset      = 1'b0;
        bus.pin_in = 32'h0;
        tick();
        rise_edge(33'h998);
        rise_edge(33'h997);
        n_cmp++; if (bus.cap_count !== 5'd0) begin n_err++; $display("FAIL mid_off_count got %0d want 0", bus.cap_count); end
        do_setcap(32'h25);
        tick();
        rise_edge(33'h777);
        n_cmp++; if (bus.cap_count !== 5'd1) begin n_err++; $display("FAIL resume_count got %0d want 1", bus.cap_count); end
        n_cmp++; if (bus.cap_data !== 33'h777) begin n_err++; $display("FAIL resume_data got %h want 000000777", bus.cap_data); end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.setcap  = 1'b0;
        bus.data    = 32'h0;
        bus.pin_in  = 32'h0;
        bus.phs     = 33'h0;
        bus.rd      = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_rise_capture();
        test_arming();
        test_overflow();
        test_full_boundary();
        test_flush_carry();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
